// File: rtl/wb_arbiter_pkg.sv
// Shared widths and producer encoding for the register-file writeback arbiter.
package wb_arbiter_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 1 << REG_W;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    // Which writeback source owns the RF write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_LSU  = 2'd2,
        SRC_MDU  = 2'd3
    } producer_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the producers, decode and the arbiter; the arbiter takes the slave view.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic     pipe_we;
    reg_idx_t pipe_wR;
    data_t    pipe_wD;

    logic     lsu_valid;
    logic     lsu_ready;
    reg_idx_t lsu_wR;
    data_t    lsu_wD;

    logic     mdu_valid;
    logic     mdu_ready;
    reg_idx_t mdu_wR;
    data_t    mdu_wD;

    logic     issue_long;
    reg_idx_t issue_rd;

    reg_idx_t rR1;
    reg_idx_t rR2;
    logic     rs1_busy;
    logic     rs2_busy;

    logic     wb_stall;

    logic     rf_we;
    reg_idx_t rf_wR;
    data_t    rf_wD;

    modport slave (
        input  pipe_we, pipe_wR, pipe_wD,
        input  lsu_valid, lsu_wR, lsu_wD,
        output lsu_ready,
        input  mdu_valid, mdu_wR, mdu_wD,
        output mdu_ready,
        input  issue_long, issue_rd,
        input  rR1, rR2,
        output rs1_busy, rs2_busy,
        output wb_stall,
        output rf_we, rf_wR, rf_wD
    );

    modport master (
        output pipe_we, pipe_wR, pipe_wD,
        output lsu_valid, lsu_wR, lsu_wD,
        input  lsu_ready,
        output mdu_valid, mdu_wR, mdu_wD,
        input  mdu_ready,
        output issue_long, issue_rd,
        output rR1, rR2,
        input  rs1_busy, rs2_busy,
        input  wb_stall,
        input  rf_we, rf_wR, rf_wD
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard for registers with an outstanding long-latency write; x0 is never busy.
module wb_scoreboard
    import wb_arbiter_pkg::*;
(
    input  logic     cpu_clk,
    input  logic     cpu_rst,
    input  logic     set_en,
    input  reg_idx_t set_rd,
    input  logic     clr_en,
    input  reg_idx_t clr_rd,
    input  reg_idx_t q1_rd,
    output logic     q1_busy,
    input  reg_idx_t q2_rd,
    output logic     q2_busy
);

    logic [NUM_REGS-1:1] busy;
    logic [NUM_REGS-1:1] busy_nxt;
    logic [NUM_REGS-1:0] busy_ext;

    // NOTE: busy_nxt is assigned in full before the loop, so no path leaves it unassigned (no latch).
    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < int'(NUM_REGS); i++) begin
            if (clr_en && clr_rd == reg_idx_t'(i)) busy_nxt[i] = 1'b0;
            // Evaluated after the clear so a same-edge issue keeps the register busy.
            if (set_en && set_rd == reg_idx_t'(i)) busy_nxt[i] = 1'b1;
        end
    end

    // NOTE: the busy bits are plain flops, not a RAM, so they take the async reset like any register.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            busy <= '0;
        end else begin
            // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
            busy <= busy_nxt;
        end
    end

    assign busy_ext = {busy, 1'b0};
    assign q1_busy  = busy_ext[q1_rd];
    assign q2_busy  = busy_ext[q2_rd];

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the pipe has priority, LSU/MDU share round-robin,
// and a starvation counter stalls the pipe so long-latency results drain.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    wb_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             rr_ptr;      // 0: LSU wins a tie, 1: MDU wins a tie
    logic             rf_we_q;
    reg_idx_t         rf_wR_q;
    data_t            rf_wD_q;
    logic             rf_long_q;   // registered write came from LSU/MDU and targets x1..x31

    logic      long_pending;
    logic      stall;
    logic      lsu_grant;
    logic      mdu_grant;
    logic      long_grant;
    producer_t grant_src;
    reg_idx_t  grant_rd;
    data_t     grant_data;

    always_comb begin
        long_pending = bus.lsu_valid | bus.mdu_valid;
        stall        = !cpu_rst && long_pending && (starve_cnt == CNT_W'(STARVE_LIMIT));
        lsu_grant    = 1'b0;
        mdu_grant    = 1'b0;
        grant_src    = SRC_NONE;
        grant_rd     = '0;
        grant_data   = '0;

        if (!cpu_rst) begin
            if (bus.pipe_we && !stall) begin
                grant_src = SRC_PIPE;
            end else if (bus.lsu_valid && bus.mdu_valid) begin
                lsu_grant = !rr_ptr;
                mdu_grant = rr_ptr;
            end else begin
                lsu_grant = bus.lsu_valid;
                mdu_grant = bus.mdu_valid;
            end
        end

        if (lsu_grant) grant_src = SRC_LSU;
        if (mdu_grant) grant_src = SRC_MDU;
        long_grant = lsu_grant | mdu_grant;

        case (grant_src)
            SRC_PIPE: begin grant_rd = bus.pipe_wR; grant_data = bus.pipe_wD; end
            SRC_LSU:  begin grant_rd = bus.lsu_wR;  grant_data = bus.lsu_wD;  end
            SRC_MDU:  begin grant_rd = bus.mdu_wR;  grant_data = bus.mdu_wD;  end
            default:  begin grant_rd = '0;          grant_data = '0;          end
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            rf_we_q    <= 1'b0;
            rf_wR_q    <= '0;
            rf_wD_q    <= '0;
            rf_long_q  <= 1'b0;
            rr_ptr     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            // x0 writes complete the handshake but never reach the register file.
            rf_we_q   <= (grant_src != SRC_NONE) && (grant_rd != '0);
            rf_long_q <= long_grant && (grant_rd != '0);
            if (grant_src != SRC_NONE) begin
                rf_wR_q <= grant_rd;
                rf_wD_q <= grant_data;
            end

            if (long_grant) begin
                rr_ptr     <= ~rr_ptr;
                starve_cnt <= '0;
            end else if (long_pending && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // A long result clears its busy bit on the edge that writes it into the register file.
    wb_scoreboard u_scoreboard (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .set_en  (bus.issue_long),
        .set_rd  (bus.issue_rd),
        .clr_en  (rf_long_q),
        .clr_rd  (rf_wR_q),
        .q1_rd   (bus.rR1),
        .q1_busy (bus.rs1_busy),
        .q2_rd   (bus.rR2),
        .q2_busy (bus.rs2_busy)
    );

    assign bus.lsu_ready = lsu_grant;
    assign bus.mdu_ready = mdu_grant;
    assign bus.wb_stall  = stall;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_wR     = rf_wR_q;
    assign bus.rf_wD     = rf_wD_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive cycles a long-latency request may lose to the pipe before the pipe is stalled.
REQ-002 SHALL have port cpu_clk, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have port cpu_rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have ports pipe_we, input, 1; pipe_wR, input, 5; pipe_wD, input, 32: single-cycle writeback from main pipeline, no handshake.
REQ-005 SHALL have ports lsu_valid, input, 1; lsu_ready, output, 1; lsu_wR, input, 5; lsu_wD, input, 32: load-unit writeback, valid/ready.
REQ-006 SHALL have ports mdu_valid, input, 1; mdu_ready, output, 1; mdu_wR, input, 5; mdu_wD, input, 32: mul/div writeback, valid/ready.
REQ-007 SHALL have ports issue_long, input, 1; issue_rd, input, 5: long-latency op issued, marks issue_rd busy.
REQ-008 SHALL have ports rR1, input, 5; rR2, input, 5; rs1_busy, output, 1; rs2_busy, output, 1: scoreboard query for decode.
REQ-009 SHALL have port wb_stall, output, 1: pipeline must hold its writeback this cycle.
REQ-010 SHALL have ports rf_we, output, 1; rf_wR, output, 5; rf_wD, output, 32: registered write port to register file.

Function
REQ-011 Grant priority per cycle: pipe (pipe_we=1 and wb_stall=0) > long requests; at most one grant per cycle.
REQ-012 Long requests arbitrated round-robin via 1-bit pointer; pointer toggles to the other unit only after a long grant; both valid -> pointer's unit wins.
REQ-013 lsu_ready/mdu_ready SHALL be combinational, high only in the cycle that unit is granted; transfer = valid&ready.
REQ-014 Granted write SHALL appear on rf_we/rf_wR/rf_wD one cycle after grant (latency 1); no grant -> rf_we=0 next cycle, rf_wR/rf_wD hold.
REQ-015 Writes to x0 SHALL be accepted (handshake completes) but produce rf_we=0.
REQ-016 Starvation counter: increments each cycle any long valid is pending and not granted, clears on any long grant; saturates at STARVE_LIMIT.
REQ-017 wb_stall SHALL be 1 when counter equals STARVE_LIMIT and a long valid is pending; in that cycle pipe_we is ignored and a long request is granted.
REQ-018 Scoreboard busy[31:1]: set on issue_long for issue_rd != 0; cleared at the clock edge on which the long write commits to RF (rf_we=1 from a long grant).
REQ-019 Same-edge set and clear of one register: set wins.
REQ-020 rs1_busy/rs2_busy combinational from busy bits; rR==0 -> 0.
REQ-021 Pipe writes SHALL NOT alter busy bits.

Reset
REQ-022 cpu_rst asserted SHALL immediately clear rf_we, rf_wR, rf_wD, busy[31:1], RR pointer (lsu first), starvation counter; readies and wb_stall drive 0 while reset held.
REQ-023 Reset mid-transfer SHALL drop any granted-but-uncommitted write.

Structure
REQ-024 Register-index width (5), data width (32), and producer-ID encoding (PIPE, LSU, MDU) SHALL live in the shared defines package.
REQ-025 Scoreboard SHALL be a sub-module wb_scoreboard (set/clear ports, two query ports); arbitration and output register stay in wb_arbiter.

Verification
REQ-026 pipe_we=1, wR=5, wD=0xDEAD_BEEF -> next cycle rf_we=1, rf_wR=5, rf_wD=0xDEADBEEF.
REQ-027 lsu_valid and mdu_valid both held, no pipe, after reset -> grants LSU, MDU, LSU alternately, one per cycle.
REQ-028 lsu_valid held, pipe_we=1 every cycle, STARVE_LIMIT=3 -> cycles 1-3 pipe granted, cycle 4 wb_stall=1 and lsu_ready=1.
REQ-029 issue_long rd=7 -> rs1_busy=1 for rR1=7; mdu writes rd=7 -> busy stays 1 through rf_we cycle, 0 after commit edge.
REQ-030 issue_long rd=9 in the same cycle as committing long write to rd=9 -> busy[9] remains 1; mdu write to rd=0 -> mdu_ready=1, rf_we=0.
REQ-031 cpu_rst pulsed asynchronously between grant and commit -> rf_we=0, all busy=0 with no clock edge required.
